// File: rtl/lab2_proc_imul_arb_pkg.sv
// lab2_proc_imul_arb_pkg: shared state encoding and pointer sizing for the imul arbiter
package lab2_proc_imul_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  localparam int ARB_NUM_REQS_DFLT = 4;
  localparam int ARB_PTR_NBITS = $clog2(ARB_NUM_REQS_DFLT);
  function automatic int arb_ptr_nbits(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/lab2_proc_RoundRobinPickVRTL.sv
// lab2_proc_RoundRobinPickVRTL: combinational round-robin pick, first valid at or after ptr
// Ports: val (per-requester valid), ptr (highest-priority index), grant (picked index), any_val (|val)
module lab2_proc_RoundRobinPickVRTL #(
  parameter int p_num_reqs  = 4,
  parameter int p_ptr_nbits = $clog2(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0]  val,
  input  logic [p_ptr_nbits-1:0] ptr,
  output logic [p_ptr_nbits-1:0] grant,
  output logic                   any_val
);
  localparam int PW1 = p_ptr_nbits + 1;
  logic [p_num_reqs-1:0]  rot;
  logic [p_ptr_nbits-1:0] off;
  logic [p_ptr_nbits:0]   sum;
  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = p_num_reqs'({val, val} >> ptr);
    off = '0;
    for (int k = p_num_reqs - 1; k >= 0; k--) off = rot[k] ? p_ptr_nbits'(k) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    grant = (sum >= PW1'(p_num_reqs)) ? p_ptr_nbits'(sum - PW1'(p_num_reqs)) : sum[p_ptr_nbits-1:0];
  end
  assign any_val = |val;
endmodule

// File: rtl/lab2_proc_imul_arbiter.sv
// lab2_proc_imul_arbiter: round-robin sharing of one iterative multiplier, one transaction in flight
// Ports: clk, reset (async, active-low); req_* / resp_* per-requester val/rdy with flattened req_msg
//        and broadcast resp_msg; mul_req_* / mul_resp_* to the shared multiplier; owner, grant_count debug
module lab2_proc_imul_arbiter
  import lab2_proc_imul_arb_pkg::*;
#(
  parameter int p_num_reqs   = 4,
  parameter int p_req_nbits  = 64,
  parameter int p_resp_nbits = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [p_num_reqs-1:0]                  req_val,
  output logic [p_num_reqs-1:0]                  req_rdy,
  input  logic [p_num_reqs*p_req_nbits-1:0]      req_msg,
  output logic [p_num_reqs-1:0]                  resp_val,
  input  logic [p_num_reqs-1:0]                  resp_rdy,
  output logic [p_resp_nbits-1:0]                resp_msg,
  output logic                                   mul_req_val,
  input  logic                                   mul_req_rdy,
  output logic [p_req_nbits-1:0]                 mul_req_msg,
  input  logic                                   mul_resp_val,
  output logic                                   mul_resp_rdy,
  input  logic [p_resp_nbits-1:0]                mul_resp_msg,
  output logic [arb_ptr_nbits(p_num_reqs)-1:0]   owner,
  output logic [31:0]                            grant_count
);
  localparam int PW = arb_ptr_nbits(p_num_reqs);
  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, grant;
  logic [31:0]   grant_count_q, grant_count_d;
  logic          any_val;
  lab2_proc_RoundRobinPickVRTL #(.p_num_reqs(p_num_reqs), .p_ptr_nbits(PW)) u_pick (
    .val(req_val), .ptr(ptr_q), .grant(grant), .any_val(any_val)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    grant_count_d = grant_count_q;
    req_rdy = '0;
    resp_val = '0;
    mul_req_val = 1'b0;
    mul_resp_rdy = 1'b0;
    mul_req_msg = req_msg[grant*p_req_nbits +: p_req_nbits];
    resp_msg = mul_resp_msg;
    if (state_q == ARB_IDLE) begin
      mul_req_val = any_val;
      req_rdy[grant] = mul_req_rdy;
      if (any_val && mul_req_rdy) begin
        owner_d = grant;
        grant_count_d = grant_count_q + 32'd1;
        state_d = ARB_BUSY;
      end
    end else begin
      resp_val[owner_q] = mul_resp_val;
      mul_resp_rdy = resp_rdy[owner_q];
      // Last-served requester drops to lowest priority once its response is delivered.
      if (mul_resp_val && resp_rdy[owner_q]) begin
        ptr_d = (owner_q == PW'(p_num_reqs - 1)) ? '0 : owner_q + PW'(1);
        state_d = ARB_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      grant_count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      grant_count_q <= grant_count_d;
    end
  end
  assign owner = owner_q;
  assign grant_count = grant_count_q;
endmodule

// File: tb/tb_lab2_proc_imul_arbiter.sv
// tb_lab2_proc_imul_arbiter: directed scenarios against a small fixed-latency multiplier model
module tb_lab2_proc_imul_arbiter;
  localparam int LAT = 3;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req_val = '0;
  logic [3:0]   req_rdy;
  logic [255:0] req_msg = '0;
  logic [3:0]   resp_val;
  logic [3:0]   resp_rdy = 4'b1111;
  logic [31:0]  resp_msg;
  logic         mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [63:0]  mul_req_msg;
  logic [31:0]  mul_resp_msg;
  logic [1:0]   owner;
  logic [31:0]  grant_count;
  logic         m_busy, force_resp = 1'b0;
  int           m_cnt;
  logic [31:0]  m_res;
  int           errors = 0, checks = 0;

  always #5 clk = ~clk;

  lab2_proc_imul_arbiter dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .owner(owner), .grant_count(grant_count)
  );

  assign mul_req_rdy = !m_busy;
  assign mul_resp_val = (m_busy && m_cnt == 0) || force_resp;
  assign mul_resp_msg = m_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_cnt <= 0;
      m_res <= '0;
    end else if (!m_busy && mul_req_val) begin
      m_busy <= 1'b1;
      m_cnt <= LAT;
      m_res <= mul_req_msg[63:32] * mul_req_msg[31:0];
    end else if (m_busy && m_cnt != 0) m_cnt <= m_cnt - 1;
    else if (m_busy && mul_resp_rdy) m_busy <= 1'b0;
  end

  task automatic set_msg(input int i, input logic [31:0] a, input logic [31:0] b);
    req_msg[i*64 +: 64] = {a, b};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_resp();
    int k = 0;
    while (resp_val == '0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) begin
      checks++; errors++;
      $display("FAIL resp_timeout: no resp_val within 50 cycles");
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL rst_resp_val: got %b want 0000", resp_val); end
    checks++; if (mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_mul_resp_rdy: got %b want 0", mul_resp_rdy); end
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL rst_grant_count: got %0d want 0", grant_count); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d want 0", owner); end
    checks++; if (mul_req_val !== 1'b0) begin errors++; $display("FAIL rst_mul_req_val: got %b want 0", mul_req_val); end
    req_val = 4'b0001;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL rst_req_rdy_comb: got %b want 0001", req_rdy); end
    req_val = 4'b0000;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (grant_count !== 32'd0) begin errors++; $display("FAIL rst_idle_count: got %0d want 0", grant_count); end
  endtask

  task automatic test_single();
    set_msg(2, 32'd7, 32'd6);
    req_val = 4'b0100;
    #1;
    checks++; if (req_rdy !== 4'b0100) begin errors++; $display("FAIL single_req_rdy: got %b want 0100", req_rdy); end
    checks++; if (mul_req_msg !== {32'd7, 32'd6}) begin errors++; $display("FAIL single_mul_msg: got %h want %h", mul_req_msg, {32'd7, 32'd6}); end
    @(posedge clk); #1;
    req_val = 4'b0000;
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d want 2", owner); end
    wait_resp();
    checks++; if (resp_val !== 4'b0100) begin errors++; $display("FAIL single_resp_val: got %b want 0100", resp_val); end
    checks++; if (resp_msg !== 32'd42) begin errors++; $display("FAIL single_resp_msg: got %0d want 42", resp_msg); end
    checks++; if (grant_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d want 1", grant_count); end
    @(posedge clk); #1;
    checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL single_idle_resp: got %b want 0000", resp_val); end
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b1000) begin errors++; $display("FAIL single_ptr3: got %b want 1000", req_rdy); end
    req_val = 4'b0000;
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) set_msg(i, i + 1, 32'd10);
    req_val = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_resp();
      checks++; if (resp_val !== 4'(1 << (n % 4))) begin errors++; $display("FAIL cont_order%0d: got %b want %b", n, resp_val, 4'(1 << (n % 4))); end
      checks++; if (owner !== 2'(n % 4)) begin errors++; $display("FAIL cont_owner%0d: got %0d want %0d", n, owner, n % 4); end
      checks++; if (resp_msg !== 32'(10 * (n % 4 + 1))) begin errors++; $display("FAIL cont_msg%0d: got %0d want %0d", n, resp_msg, 10 * (n % 4 + 1)); end
      @(posedge clk); #1;
    end
    checks++; if (grant_count !== 32'd6) begin errors++; $display("FAIL cont_count: got %0d want 6", grant_count); end
    checks++; if (resp_val !== 4'b0000) begin errors++; $display("FAIL cont_idle_gap: got %b want 0000", resp_val); end
    req_val = 4'b0000;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_msg(1, 32'd5, 32'd9);
    resp_rdy = 4'b1101;
    req_val = 4'b0010;
    @(posedge clk); #1;
    req_val = 4'b0000;
    wait_resp();
    req_val = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      checks++; if (mul_resp_rdy !== 1'b0 || req_rdy !== 4'b0000 || mul_req_val !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got rdy=%b req_rdy=%b mreq=%b want 0 0000 0", c, mul_resp_rdy, req_rdy, mul_req_val); end
      checks++; if (resp_msg !== 32'd45 || resp_val !== 4'b0010) begin errors++; $display("FAIL bp_hold%0d: got msg=%0d val=%b want 45 0010", c, resp_msg, resp_val); end
      @(posedge clk); #1;
    end
    resp_rdy = 4'b1111;
    #1;
    checks++; if (mul_resp_rdy !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", mul_resp_rdy); end
    @(posedge clk); #1;
    checks++; if (resp_val !== 4'b0000 || req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_idle: got val=%b req_rdy=%b want 0000 0100", resp_val, req_rdy); end
    req_val = 4'b0000;
  endtask

  task automatic test_rotation();
    do_reset();
    set_msg(0, 32'd2, 32'd3);
    set_msg(3, 32'd4, 32'd5);
    req_val = 4'b0001;
    @(posedge clk); #1;
    req_val = 4'b0000;
    wait_resp();
    @(posedge clk); #1;
    req_val = 4'b1001;
    wait_resp();
    checks++; if (resp_val !== 4'b1000 || resp_msg !== 32'd20) begin errors++; $display("FAIL rot_first: got %b/%0d want 1000/20", resp_val, resp_msg); end
    @(posedge clk); #1;
    wait_resp();
    checks++; if (resp_val !== 4'b0001 || resp_msg !== 32'd6) begin errors++; $display("FAIL rot_second: got %b/%0d want 0001/6", resp_val, resp_msg); end
    @(posedge clk); #1;
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0010) begin errors++; $display("FAIL rot_ptr1: got %b want 0010", req_rdy); end
    req_val = 4'b0000;
  endtask

  task automatic test_reset_mid_busy();
    set_msg(2, 32'd3, 32'd4);
    req_val = 4'b0100;
    @(posedge clk); #1;
    req_val = 4'b0000;
    @(posedge clk); #2;
    checks++; if (owner !== 2'd2 || grant_count === 32'd0) begin errors++; $display("FAIL mid_busy_pre: got owner=%0d count=%0d want 2 nonzero", owner, grant_count); end
    reset = 1'b0;
    #1;
    checks++; if (resp_val !== 4'b0000 || grant_count !== 32'd0 || owner !== 2'd0 || mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL mid_busy_abort: got val=%b count=%0d owner=%0d rdy=%b want 0000 0 0 0", resp_val, grant_count, owner, mul_resp_rdy); end
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL mid_busy_idle: got %b want 0001", req_rdy); end
    req_val = 4'b0000;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    set_msg(3, 32'd11, 32'd3);
    req_val = 4'b1000;
    @(posedge clk); #1;
    req_val = 4'b0000;
    wait_resp();
    checks++; if (resp_val !== 4'b1000 || resp_msg !== 32'd33 || grant_count !== 32'd1) begin errors++; $display("FAIL mid_busy_after: got %b/%0d/%0d want 1000/33/1", resp_val, resp_msg, grant_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_spurious();
    force_resp = 1'b1;
    #1;
    checks++; if (mul_resp_rdy !== 1'b0 || resp_val !== 4'b0000) begin errors++; $display("FAIL spur_ignore: got rdy=%b val=%b want 0 0000", mul_resp_rdy, resp_val); end
    @(posedge clk); #1;
    force_resp = 1'b0;
    checks++; if (grant_count !== 32'd1 || owner !== 2'd3) begin errors++; $display("FAIL spur_state: got count=%0d owner=%0d want 1 3", grant_count, owner); end
    req_val = 4'b1111;
    #1;
    checks++; if (req_rdy !== 4'b0001 || mul_req_val !== 1'b1) begin errors++; $display("FAIL spur_idle: got req_rdy=%b mreq=%b want 0001 1", req_rdy, mul_req_val); end
    req_val = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_rotation();
    test_reset_mid_busy();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lab2_proc_imul_arbiter.md
# lab2_proc_imul_arbiter

Round-robin arbiter and sequencer that shares one iterative integer multiplier (the lab1 IntMulAlt unit, 64-bit request, 32-bit response, latency-insensitive val/rdy) among `p_num_reqs` requesters. Examples are the X stages of several cores in a multicore build, or a core plus an accelerator. The block allows one transaction in flight at a time. It records which requester owns the multiplier and returns the response to that requester only. It sits between the requesters' `imul_req_*`/`imul_resp_*` ports and the single shared multiplier instance.

## Interface
- `p_num_reqs`, default 4: number of requesters (2 to 8).
- `p_req_nbits`, default 64: request message width, `{op1, op2}`.
- `p_resp_nbits`, default 32: response message width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_val`  in  `p_num_reqs`  per-requester request valid.
- `req_rdy`  out  `p_num_reqs`  per-requester request ready.
- `req_msg`  in  `p_num_reqs*p_req_nbits`  flattened requests; requester i occupies bits `[i*p_req_nbits +: p_req_nbits]`.
- `resp_val`  out  `p_num_reqs`  per-requester response valid.
- `resp_rdy`  in  `p_num_reqs`  per-requester response ready.
- `resp_msg`  out  `p_resp_nbits`  response, broadcast to all requesters; qualified by `resp_val[i]`.
- `mul_req_val`, `mul_req_rdy`, `mul_req_msg`: out / in / out, 1 / 1 / `p_req_nbits`; request port to the multiplier.
- `mul_resp_val`, `mul_resp_rdy`, `mul_resp_msg`: in / out / in, 1 / 1 / `p_resp_nbits`; response port from the multiplier.
- `owner`  out  `$clog2(p_num_reqs)`  index of the requester holding the grant (debug).
- `grant_count`  out  32  number of accepted requests since reset; wraps at 2^32.

## Operation

The FSM has two states.

- **IDLE:**
  - `grant` is the first i with `req_val[i]=1`, searching circularly from `ptr`.
  - `mul_req_val = |req_val`.
  - `mul_req_msg` is the granted requester's slice.
  - `req_rdy[grant] = mul_req_rdy`; all other `req_rdy` bits are 0.
  - `grant` is combinational and may change between cycles until the handshake fires. Requesters hold `val` and `msg` per val/rdy rules.
  - On fire (`mul_req_val & mul_req_rdy`): `owner <= grant`, `grant_count++`, go to BUSY.
- **BUSY:**
  - `mul_req_val=0` and all `req_rdy=0`.
  - `resp_val[owner] = mul_resp_val`; all other `resp_val` bits are 0.
  - `mul_resp_rdy = resp_rdy[owner]`.
  - `resp_msg = mul_resp_msg`.
  - On response fire: `ptr <= owner+1` (mod `p_num_reqs`), go to IDLE.
- **Priority rules:**
  - The most recently served requester gets lowest priority.
  - `ptr` changes only on response fire. It never advances on request accept or on idle cycles.
- **Output values:**
  - `resp_val` is 0 in IDLE.
  - A `mul_resp_val` that arrives in IDLE is a protocol error. The block ignores it and keeps `mul_resp_rdy=0`.

## Timing
- Reset (`reset`=0, asynchronous):
  - state=IDLE, `ptr`=0, `owner`=0, `grant_count`=0.
  - Consequently `resp_val`=0 and `mul_resp_rdy`=0.
  - `req_rdy` and `mul_req_val` follow the IDLE equations combinationally.
- Reset assertion mid-transaction:
  - The block aborts immediately to IDLE.
  - The integrator resets the multiplier from the same net (inverted to active-high) so no stale response survives.
- All request-side and response-side paths are combinational pass-through. The arbiter adds 0 cycles of latency to request acceptance and 0 cycles to response delivery.
- Issue rate is one transaction per 2 + multiplier-latency cycles at best. The IDLE cycle after a response is mandatory: a request cannot be accepted in the same cycle as a response fire.
- `resp_rdy[owner]` low stalls BUSY indefinitely. Other requesters see `req_rdy=0` throughout.
- With `p_num_reqs` requesters continuously valid, each receives exactly one grant per `p_num_reqs` transactions (no starvation).

## Structure
- Package `lab2_proc_imul_arb_pkg`:
  - state encoding enum `{ARB_IDLE, ARB_BUSY}`;
  - localparam for the pointer width, `$clog2(p_num_reqs)`.
- Sub-module `lab2_proc_RoundRobinPickVRTL`: purely combinational. Inputs are a `p_num_reqs` valid vector and `ptr`. Outputs are the grant index and `any_val`. It is reused later for dmem port sharing.
- The top level holds the FSM, the `ptr`/`owner`/`grant_count` registers, and the request and response muxes.

## Test plan
- **Single requester:** after reset, `req_val[2]=1` with `msg={32'd7,32'd6}`.
  - Same cycle: `req_rdy[2]=1`.
  - After the multiplier completes: `resp_val[2]=1`, `resp_msg=42`, other `resp_val` bits 0, `grant_count=1`, `ptr=3`.
- **Full contention:** all 4 requesters valid continuously from reset.
  - Grant order is 0,1,2,3,0,1.
  - `owner` matches each response.
  - `grant_count=6` after 6 responses.
- **Response backpressure:** hold `resp_rdy[1]=0` for 10 cycles while BUSY for owner 1.
  - `mul_resp_rdy=0` and all `req_rdy=0` for those 10 cycles.
  - `resp_msg` is stable.
  - Release the hold: the response fires and the state returns to IDLE.
- **Priority rotation:** requesters 0 and 3 valid, `ptr=1` → requester 3 is granted first, then 0; afterwards `ptr=1`.
- **Reset mid-BUSY:** drive `reset`=0 asynchronously mid-BUSY (between clock edges).
  - Immediately: `resp_val`=0, state IDLE, `ptr`=0, `grant_count`=0.
  - The next request after release is served normally.
- **Spurious response:** `mul_resp_val=1` in IDLE → `mul_resp_rdy=0`, all `resp_val`=0, no state change.
